// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: the buffered writeback entry, the
// round-robin source selector and the default result-buffer depth.
package rv32_pkg;

  // Default number of long-latency results the writeback buffer can hold.
  localparam int WB_FIFO_DEPTH = 4;

  // One pending register-file write.
  typedef struct packed {
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] data;
  } wb_entry_t;

  // Which long-latency source wins the next tie.
  typedef enum logic {
    RR_MD  = 1'b0,
    RR_FPU = 1'b1
  } rr_sel_e;

  // A write to integer x0 has no architectural effect.
  function automatic logic wb_is_x0(input logic [4:0] rd, input logic fp);
    return (fp == 1'b0) && (rd == 5'd0);
  endfunction

endpackage

// File: rtl/rv32_wb_arbiter_if.sv
// Bundle of the writeback arbiter's pipeline, long-latency source and
// register-file write signals. The master side produces results; the
// slave side is the arbiter.
interface rv32_wb_arbiter_if #(
  parameter int FIFO_DEPTH = rv32_pkg::WB_FIFO_DEPTH
);
  import rv32_pkg::*;

  logic                             pipe_we;
  logic [4:0]                       pipe_rd;
  logic                             pipe_fp;
  logic [31:0]                      pipe_data;

  logic                             md_valid;
  logic                             md_ready;
  logic [4:0]                       md_rd;
  logic [31:0]                      md_data;

  logic                             fpu_valid;
  logic                             fpu_ready;
  logic [4:0]                       fpu_rd;
  logic                             fpu_fp;
  logic [31:0]                      fpu_data;

  logic                             rf_we;
  logic [4:0]                       rf_rd;
  logic                             rf_fp;
  logic [31:0]                      rf_data;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count;

  modport master (
    output pipe_we, pipe_rd, pipe_fp, pipe_data,
    output md_valid, md_rd, md_data,
    output fpu_valid, fpu_rd, fpu_fp, fpu_data,
    input  md_ready, fpu_ready,
    input  rf_we, rf_rd, rf_fp, rf_data, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_fp, pipe_data,
    input  md_valid, md_rd, md_data,
    input  fpu_valid, fpu_rd, fpu_fp, fpu_data,
    output md_ready, fpu_ready,
    output rf_we, rf_rd, rf_fp, rf_data, fifo_count
  );

endinterface

// File: rtl/rv32_wb_fifo.sv
// Synchronous FIFO of pending writeback entries. Full/empty come from an
// occupancy counter; read/write pointers wrap naturally at the power-of-two
// depth. Pushes while full and pops while empty are ignored.
module rv32_wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           i_push,
  input  wb_entry_t                      i_push_entry,
  input  logic                           i_pop,
  output wb_entry_t                      o_head,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array: written at the tail on an accepted push; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointers and occupancy count; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file writeback arbiter. The in-order pipeline owns the write port
// whenever it writes; mul/div and FPU results are accepted round-robin into
// a small FIFO and drained in acceptance order through otherwise-free slots.
// The register-file write port is registered (one cycle of latency).
module rv32_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pipe_we_i,
  input  logic [4:0]                         pipe_rd_i,
  input  logic                               pipe_fp_i,
  input  logic [31:0]                        pipe_data_i,
  input  logic                               md_valid_i,
  output logic                               md_ready_o,
  input  logic [4:0]                         md_rd_i,
  input  logic [31:0]                        md_data_i,
  input  logic                               fpu_valid_i,
  output logic                               fpu_ready_o,
  input  logic [4:0]                         fpu_rd_i,
  input  logic                               fpu_fp_i,
  input  logic [31:0]                        fpu_data_i,
  output logic                               rf_we_o,
  output logic [4:0]                         rf_rd_o,
  output logic                               rf_fp_o,
  output logic [31:0]                        rf_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  rr_sel_e     r_rr;
  logic        r_rf_we;
  logic [4:0]  r_rf_rd;
  logic        r_rf_fp;
  logic [31:0] r_rf_data;

  logic        w_full;
  logic        w_empty;
  wb_entry_t   w_head;
  logic        w_md_ready;
  logic        w_fpu_ready;
  logic        w_md_acc;
  logic        w_fpu_acc;
  logic        w_push;
  wb_entry_t   w_push_entry;
  logic        w_pipe_wr;
  logic        w_pop;
  logic        w_nxt_we;
  logic [4:0]  w_nxt_rd;
  logic        w_nxt_fp;
  logic [31:0] w_nxt_data;

  // Source readiness: nothing while full, otherwise the lone requester or the round-robin winner.
  always_comb begin
    w_md_ready  = 1'b0;
    w_fpu_ready = 1'b0;
    if (w_full) begin
      w_md_ready  = 1'b0;
      w_fpu_ready = 1'b0;
    end else if (md_valid_i && fpu_valid_i) begin
      w_md_ready  = (r_rr == RR_MD);
      w_fpu_ready = (r_rr == RR_FPU);
    end else begin
      w_md_ready  = 1'b1;
      w_fpu_ready = 1'b1;
    end
  end

  assign md_ready_o  = w_md_ready;
  assign fpu_ready_o = w_fpu_ready;
  assign w_md_acc    = md_valid_i & w_md_ready;
  assign w_fpu_acc   = fpu_valid_i & w_fpu_ready;
  assign w_push      = w_md_acc | w_fpu_acc;

  // Enqueue payload from whichever source was accepted; mul/div always targets the integer file.
  always_comb begin
    w_push_entry = '{rd: fpu_rd_i, fp: fpu_fp_i, data: fpu_data_i};
    if (w_md_acc) begin
      w_push_entry = '{rd: md_rd_i, fp: 1'b0, data: md_data_i};
    end else begin
      w_push_entry = '{rd: fpu_rd_i, fp: fpu_fp_i, data: fpu_data_i};
    end
  end

  // Round-robin pointer hands priority to the other source after each accepted transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= RR_MD;
    end else if (w_md_acc) begin
      r_rr <= RR_FPU;
    end else if (w_fpu_acc) begin
      r_rr <= RR_MD;
    end else begin
      r_rr <= r_rr;
    end
  end

  rv32_wb_fifo #(
    .DEPTH        (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (fifo_count_o)
  );

  // A pipeline write to integer x0 leaves the slot free for the buffer.
  assign w_pipe_wr = pipe_we_i & ~wb_is_x0(pipe_rd_i, pipe_fp_i);
  assign w_pop     = ~w_pipe_wr & ~w_empty;

  // Next write-port contents: pipeline first, then the FIFO head; x0 heads are dropped.
  always_comb begin
    w_nxt_we   = 1'b0;
    w_nxt_rd   = r_rf_rd;
    w_nxt_fp   = r_rf_fp;
    w_nxt_data = r_rf_data;
    if (w_pipe_wr) begin
      w_nxt_we   = 1'b1;
      w_nxt_rd   = pipe_rd_i;
      w_nxt_fp   = pipe_fp_i;
      w_nxt_data = pipe_data_i;
    end else if (w_pop) begin
      if (wb_is_x0(w_head.rd, w_head.fp)) begin
        w_nxt_we = 1'b0;
      end else begin
        w_nxt_we   = 1'b1;
        w_nxt_rd   = w_head.rd;
        w_nxt_fp   = w_head.fp;
        w_nxt_data = w_head.data;
      end
    end else begin
      w_nxt_we = 1'b0;
    end
  end

  // Registered register-file write port; payload holds when no write is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rf_we   <= 1'b0;
      r_rf_rd   <= 5'd0;
      r_rf_fp   <= 1'b0;
      r_rf_data <= 32'd0;
    end else begin
      r_rf_we   <= w_nxt_we;
      r_rf_rd   <= w_nxt_rd;
      r_rf_fp   <= w_nxt_fp;
      r_rf_data <= w_nxt_data;
    end
  end

  assign rf_we_o   = r_rf_we;
  assign rf_rd_o   = r_rf_rd;
  assign rf_fp_o   = r_rf_fp;
  assign rf_data_o = r_rf_data;

endmodule

// File: doc/rv32_wb_arbiter.md
RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, number of completed long-latency results buffered (power of two, >=2).
REQ-002 SHALL have port: clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pipe_we_i  input  1  in-order pipeline requests a register write this cycle.
REQ-005 SHALL have port: pipe_rd_i  input  5  pipeline destination register.
REQ-006 SHALL have port: pipe_fp_i  input  1  pipeline destination is FP register file (0 = integer).
REQ-007 SHALL have port: pipe_data_i  input  32  pipeline write data.
REQ-008 SHALL have port: md_valid_i / md_ready_o  input/output  1  mul/div result handshake.
REQ-009 SHALL have port: md_rd_i, md_data_i  input  5, 32  mul/div destination (always integer) and result.
REQ-010 SHALL have port: fpu_valid_i / fpu_ready_o  input/output  1  FPU result handshake.
REQ-011 SHALL have port: fpu_rd_i, fpu_fp_i, fpu_data_i  input  5, 1, 32  FPU destination, file select, result.
REQ-012 SHALL have port: rf_we_o, rf_rd_o, rf_fp_o, rf_data_o  output  1, 5, 1, 32  registered register-file write port.
REQ-013 SHALL have port: fifo_count_o  output  $clog2(FIFO_DEPTH+1)  entries currently buffered.

Function
REQ-014 SHALL transfer a source result only in a cycle where its valid and ready are both high; sources hold valid and payload stable until accepted.
REQ-015 SHALL drive ready low for both sources whenever the FIFO is full at the start of the cycle; no enqueue-on-dequeue pass-through when full.
REQ-016 SHALL, when not full and only one source valid, assert that source's ready.
REQ-017 SHALL, when not full and both valid, assert ready only for the source selected by a 1-bit round-robin pointer; the other source's ready stays low.
REQ-018 SHALL flip the round-robin pointer to the non-accepted source after every accepted transfer; pointer resets to mul/div.
REQ-019 SHALL enqueue at most one entry {rd, fp, data} per cycle; mul/div entries have fp = 0.
REQ-020 SHALL give the pipeline absolute priority: when pipe_we_i = 1 and not (pipe_fp_i = 0 and pipe_rd_i = 0), register the pipeline write onto rf_* next edge; pipeline is never stalled.
REQ-021 SHALL treat a pipeline write to integer x0 as no write (slot free).
REQ-022 SHALL, in a free slot with FIFO non-empty, pop the head and register it onto rf_* next edge.
REQ-023 SHALL pop and discard a head entry targeting integer x0, driving rf_we_o = 0 that cycle.
REQ-024 SHALL give every write exactly one cycle of output latency; a long-latency result accepted in cycle N appears on rf_* no earlier than N+2.
REQ-025 SHALL preserve acceptance order within the FIFO (strict FIFO, no reordering).
REQ-026 SHALL allow simultaneous enqueue and dequeue when not full; fifo_count_o unchanged in that case.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit or the counter.
REQ-028 SHALL hold rf_rd_o, rf_fp_o, rf_data_o at previous values when rf_we_o = 0.

Reset
REQ-029 SHALL on rst_ni low, immediately and asynchronously clear: rf_we_o = 0, rf_rd_o = 0, rf_fp_o = 0, rf_data_o = 0, FIFO pointers and count = 0, RR pointer = mul/div.
REQ-030 SHALL discard all buffered entries on reset mid-operation; ready outputs are high for any valid source in the first cycle after release.

Structure
REQ-031 SHALL take wb_entry_t {rd[4:0], fp, data[31:0]} and the FIFO_DEPTH default from the shared rv32_pkg package.
REQ-032 SHALL instantiate one sub-module, rv32_wb_fifo (synchronous FIFO of wb_entry_t with push/pop/full/empty/count); arbitration and output register stay in the top.

Verification
REQ-033 SHALL cover: md_valid with rd=5, data=0x0000_0064, pipe idle -> md_ready=1, rf_we=1, rd=5, data=0x64 exactly two edges later.
REQ-034 SHALL cover: md and fpu valid same cycle, pointer at mul/div -> md accepted first, fpu next cycle, rf writes in order md then fpu.
REQ-035 SHALL cover: pipe_we held high (rd=1) for 6 cycles while 5 md results arrive -> first 4 accepted, ready low at count=4, all drain in order once pipe_we drops.
REQ-036 SHALL cover: FPU result fp=0, rd=0 (integer x0) -> popped, rf_we_o stays 0, count returns to 0.
REQ-037 SHALL cover: rst_ni asserted with count=3 -> rf_we_o=0 and fifo_count_o=0 without a clock edge; no stale entry written after release.
